i2c_reg_sequencer: RTL and testbench

// Command sequencer sitting directly upstream of the I2C byte master. Turns one

---
 rtl/i2c_reg_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: turns one single-byte register command (write: dev,reg,data;
// read: dev,reg -> data) into the enable/rw/restart/txdata/address pattern the
// downstream I2C byte master expects, and returns one response with read data
// and error status. One command in flight at a time.
module i2c_reg_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_dev,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_err,
    output logic [7:0] m_txdata,
    output logic [6:0] m_address,
    output logic       m_enable,
    output logic       m_rw,
    output logic       m_restart,
    input  logic [7:0] m_rxdata,
    input  logic       m_ack,
    input  logic       m_nack,
    input  logic       m_ready
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_NACK    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_LAUNCH, S_ADDR, S_REG, S_DATA, S_RADDR, S_RDATA, S_FINISH, S_ABORT
    } state_t;

    state_t        r_state,     w_state;
    logic          r_cmd_rw,    w_cmd_rw;
    logic [7:0]    r_wdata,     w_wdata;
    logic [7:0]    r_txdata,    w_txdata;
    logic [6:0]    r_address,   w_address;
    logic          r_enable,    w_enable;
    logic          r_mrw,       w_mrw;
    logic          r_restart,   w_restart;
    logic          r_rsp_valid, w_rsp_valid;
    logic [7:0]    r_rdata,     w_rdata;
    logic [1:0]    r_err,       w_err;
    logic [CW-1:0] r_tcnt,      w_tcnt;
    logic          w_accept;

    // cmd_ready stays low during the response cycle so a new command is taken
    // only once the previous response pulse has gone.
    assign cmd_ready = (r_state == S_IDLE) && !r_rsp_valid;
    assign w_accept  = cmd_valid && cmd_ready;

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign m_txdata  = r_txdata;
    assign m_address = r_address;
    assign m_enable  = r_enable;
    assign m_rw      = r_mrw;
    assign m_restart = r_restart;

    // State and datapath registers; reset returns everything to idle with no response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cmd_rw    <= 1'b0;
            r_wdata     <= '0;
            r_txdata    <= '0;
            r_address   <= '0;
            r_enable    <= 1'b0;
            r_mrw       <= 1'b0;
            r_restart   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_err       <= ERR_OK;
            r_tcnt      <= '0;
        end else begin
            r_state     <= w_state;
            r_cmd_rw    <= w_cmd_rw;
            r_wdata     <= w_wdata;
            r_txdata    <= w_txdata;
            r_address   <= w_address;
            r_enable    <= w_enable;
            r_mrw       <= w_mrw;
            r_restart   <= w_restart;
            r_rsp_valid <= w_rsp_valid;
            r_rdata     <= w_rdata;
            r_err       <= w_err;
            r_tcnt      <= w_tcnt;
        end
    end

    // Next-state and next-output logic; timeout overrides every other transition.
    always_comb begin
        w_state     = r_state;
        w_cmd_rw    = r_cmd_rw;
        w_wdata     = r_wdata;
        w_txdata    = r_txdata;
        w_address   = r_address;
        w_enable    = r_enable;
        w_mrw       = r_mrw;
        w_restart   = r_restart;
        w_rsp_valid = 1'b0;
        w_rdata     = r_rdata;
        w_err       = r_err;
        w_tcnt      = (r_state == S_IDLE) ? '0 : r_tcnt + CW'(1);

        if (r_state != S_IDLE && r_tcnt == TMAX) begin
            w_enable    = 1'b0;
            w_restart   = 1'b0;
            w_rsp_valid = 1'b1;
            w_err       = ERR_TIMEOUT;
            w_rdata     = '0;
            w_state     = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_cmd_rw  = cmd_rw;
                        w_wdata   = cmd_wdata;
                        w_address = cmd_dev;
                        w_txdata  = cmd_reg;
                        w_mrw     = 1'b0;
                        w_restart = 1'b0;
                        w_enable  = 1'b1;
                        w_err     = ERR_OK;
                        w_state   = S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (!m_ready) w_state = S_ADDR;
                end
                S_ADDR, S_REG, S_DATA, S_RADDR: begin
                    if (m_nack) begin
                        w_enable  = 1'b0;
                        w_restart = 1'b0;
                        w_err     = ERR_NACK;
                        w_state   = S_ABORT;
                    end else if (m_ack) begin
                        case (r_state)
                            S_ADDR: begin
                                if (r_cmd_rw) begin
                                    w_restart = 1'b1;
                                    w_mrw     = 1'b1;
                                end else begin
                                    w_txdata  = r_wdata;
                                end
                                w_state = S_REG;
                            end
                            S_REG: begin
                                if (r_cmd_rw) begin
                                    w_restart = 1'b0;
                                    w_state   = S_RADDR;
                                end else begin
                                    w_enable  = 1'b0;
                                    w_state   = S_DATA;
                                end
                            end
                            S_DATA: w_state = S_FINISH;
                            default: begin
                                w_enable = 1'b0;
                                w_state  = S_RDATA;
                            end
                        endcase
                    end
                end
                S_RDATA: begin
                    w_state = S_FINISH;
                end
                S_FINISH: begin
                    if (m_ready) begin
                        w_rsp_valid = 1'b1;
                        w_err       = ERR_OK;
                        w_rdata     = r_cmd_rw ? m_rxdata : '0;
                        w_txdata    = '0;
                        w_address   = '0;
                        w_enable    = 1'b0;
                        w_mrw       = 1'b0;
                        w_restart   = 1'b0;
                        w_state     = S_IDLE;
                    end
                end
                S_ABORT: begin
                    if (m_ready) begin
                        w_rsp_valid = 1'b1;
                        w_rdata     = '0;
                        w_state     = S_IDLE;
                    end
                end
                default: w_state = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Testbench for i2c_reg_sequencer: cycle-by-cycle vector table for the
// write / read / nack flows, plus hand-written timeout and mid-command reset checks.
module tb_i2c_reg_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready, cmd_rw;
    logic [6:0] cmd_dev;
    logic [7:0] cmd_reg, cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_err;
    logic [7:0] m_txdata;
    logic [6:0] m_address;
    logic       m_enable, m_rw, m_restart;
    logic [7:0] m_rxdata;
    logic       m_ack, m_nack, m_ready;

    int checks = 0;
    int errors = 0;
    int rv_cnt = 0;

    always #5 clk = ~clk;

    i2c_reg_sequencer #(.TIMEOUT_CYCLES(200)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_txdata(m_txdata), .m_address(m_address), .m_enable(m_enable),
        .m_rw(m_rw), .m_restart(m_restart), .m_rxdata(m_rxdata),
        .m_ack(m_ack), .m_nack(m_nack), .m_ready(m_ready)
    );

    // Count response pulses, used to prove that reset produces no response.
    always @(negedge clk) if (rsp_valid === 1'b1) rv_cnt++;

    typedef struct {
        logic       cv, rw;
        logic [6:0] dev;
        logic [7:0] rg, wd;
        logic       rdy, ack, nack;
        logic [7:0] rx;
        logic       e_crdy, e_rv;
        logic [7:0] e_rd;
        logic [1:0] e_err;
        logic [7:0] e_tx;
        logic [6:0] e_addr;
        logic       e_en, e_mrw, e_rs;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int cv, int rw, int dev, int rg, int wd,
                                int rdy, int ack, int nack, int rx,
                                int crdy, int rv, int rd, int err, int tx,
                                int addr, int en, int mrw, int rs);
        vec_t v;
        v.cv = cv[0]; v.rw = rw[0]; v.dev = dev[6:0]; v.rg = rg[7:0]; v.wd = wd[7:0];
        v.rdy = rdy[0]; v.ack = ack[0]; v.nack = nack[0]; v.rx = rx[7:0];
        v.e_crdy = crdy[0]; v.e_rv = rv[0]; v.e_rd = rd[7:0]; v.e_err = err[1:0];
        v.e_tx = tx[7:0]; v.e_addr = addr[6:0]; v.e_en = en[0]; v.e_mrw = mrw[0];
        v.e_rs = rs[0];
        return v;
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_dev = '0; cmd_reg = '0; cmd_wdata = '0;
        m_ready = 1'b1; m_ack = 1'b0; m_nack = 1'b0; m_rxdata = '0;
    endtask

    task automatic run_vec(int i);
        vec_t v;
        v = vecs[i];
        @(negedge clk);
        cmd_valid = v.cv; cmd_rw = v.rw; cmd_dev = v.dev; cmd_reg = v.rg; cmd_wdata = v.wd;
        m_ready = v.rdy; m_ack = v.ack; m_nack = v.nack; m_rxdata = v.rx;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d.cmd_ready", i), int'(cmd_ready), int'(v.e_crdy));
        chk($sformatf("v%0d.rsp_valid", i), int'(rsp_valid), int'(v.e_rv));
        chk($sformatf("v%0d.rsp_rdata", i), int'(rsp_rdata), int'(v.e_rd));
        chk($sformatf("v%0d.rsp_err",   i), int'(rsp_err),   int'(v.e_err));
        chk($sformatf("v%0d.m_txdata",  i), int'(m_txdata),  int'(v.e_tx));
        chk($sformatf("v%0d.m_address", i), int'(m_address), int'(v.e_addr));
        chk($sformatf("v%0d.m_enable",  i), int'(m_enable),  int'(v.e_en));
        chk($sformatf("v%0d.m_rw",      i), int'(m_rw),      int'(v.e_mrw));
        chk($sformatf("v%0d.m_restart", i), int'(m_restart), int'(v.e_rs));
    endtask

    initial begin
        int n;

        // cv rw dev reg wd | rdy ack nack rx || crdy rv rd err tx addr en mrw rs
        // 0-8: write 0x50/0x10/0xA5, all acked; a busy cmd_valid at row 3 is ignored
        vecs.push_back(mk(1,0,'h50,'h10,'hA5, 1,0,0,0,    0,0,0,0,'h10,'h50,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,          0,0,0,0,    0,0,0,0,'h10,'h50,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,          0,1,0,0,    0,0,0,0,'hA5,'h50,1,0,0));
        vecs.push_back(mk(1,1,'h33,'h44,'h55, 0,0,0,0,    0,0,0,0,'hA5,'h50,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,          0,1,0,0,    0,0,0,0,'hA5,'h50,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,          0,1,0,0,    0,0,0,0,'hA5,'h50,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,          0,0,0,0,    0,0,0,0,'hA5,'h50,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,          1,0,0,0,    0,1,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,          1,0,0,0,    1,0,0,0,0,0,0,0,0));
        // 9-17: read 0x50/0x22 returning 0x3C; the master's own NACK in RDATA is ignored
        vecs.push_back(mk(1,1,'h50,'h22,0,    1,0,0,0,    0,0,0,0,'h22,'h50,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,          0,0,0,0,    0,0,0,0,'h22,'h50,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,          0,1,0,0,    0,0,0,0,'h22,'h50,1,1,1));
        vecs.push_back(mk(0,0,0,0,0,          0,1,0,0,    0,0,0,0,'h22,'h50,1,1,0));
        vecs.push_back(mk(0,0,0,0,0,          0,1,0,0,    0,0,0,0,'h22,'h50,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,          0,0,1,0,    0,0,0,0,'h22,'h50,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,          0,0,0,'h3C, 0,0,0,0,'h22,'h50,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,          1,0,0,'h3C, 0,1,'h3C,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,          1,0,0,0,    1,0,'h3C,0,0,0,0,0,0));
        // 18-23: address nacked (ack and nack together, nack wins); rdata held until response
        vecs.push_back(mk(1,0,'h51,'h10,'h77, 1,0,0,0,    0,0,'h3C,0,'h10,'h51,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,          0,0,0,0,    0,0,'h3C,0,'h10,'h51,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,          0,1,1,0,    0,0,'h3C,1,'h10,'h51,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,          0,0,0,0,    0,0,'h3C,1,'h10,'h51,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,          1,0,0,0,    0,1,0,1,'h10,'h51,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,          1,0,0,0,    1,0,0,1,'h10,'h51,0,0,0));
        // 24-29: register byte nacked on a write; data byte is never enabled
        vecs.push_back(mk(1,0,'h50,'h10,'hA5, 1,0,0,0,    0,0,0,0,'h10,'h50,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,          0,0,0,0,    0,0,0,0,'h10,'h50,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,          0,1,0,0,    0,0,0,0,'hA5,'h50,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,          0,0,1,0,    0,0,0,1,'hA5,'h50,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,          1,0,0,0,    0,1,0,1,'hA5,'h50,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,          1,0,0,0,    1,0,0,1,'hA5,'h50,0,0,0));

        drive_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.cmd_ready", int'(cmd_ready), 1);
        chk("reset.rsp_valid", int'(rsp_valid), 0);
        chk("reset.rsp_rdata", int'(rsp_rdata), 0);
        chk("reset.rsp_err",   int'(rsp_err),   0);
        chk("reset.m_bus", int'({m_txdata, m_address, m_enable, m_rw, m_restart}), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(i);

        // Timeout: master never starts or acks (bus held by a foreign master)
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_dev = 7'h50; cmd_reg = 8'h10; cmd_wdata = 8'h11;
        m_ready = 1'b1; m_ack = 1'b0; m_nack = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        m_ready = 1'b0;
        n = 0;
        while (n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (rsp_valid) break;
        end
        chk("timeout.cycles",    n, 200);
        chk("timeout.rsp_err",   int'(rsp_err), 2);
        chk("timeout.m_enable",  int'(m_enable), 0);
        chk("timeout.m_restart", int'(m_restart), 0);
        chk("timeout.ready_in_rsp", int'(cmd_ready), 0);
        @(posedge clk);
        #1;
        chk("timeout.cmd_ready_after", int'(cmd_ready), 1);
        chk("timeout.rsp_pulse_len",   int'(rsp_valid), 0);

        // Reset during a read's REG phase, then a normal write
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rv_cnt = 0;
        for (int i = 9; i <= 11; i++) run_vec(i);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset.m_enable",  int'(m_enable), 0);
        chk("midreset.m_restart", int'(m_restart), 0);
        chk("midreset.cmd_ready", int'(cmd_ready), 1);
        chk("midreset.m_address", int'(m_address), 0);
        @(negedge clk);
        drive_idle();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midreset.no_rsp", rv_cnt, 0);
        for (int i = 0; i <= 8; i++) run_vec(i);
        chk("midreset.one_rsp_after_write", rv_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
